ldpc_pin_host: RTL
==================

Name: ldpc_pin_host

Overview:
- Host-side master for the LDPC core's serial pin bus: pin_in_out_sel (register select), pin_inputnoutput (direction, 1 = host writes), pin_input (serial data to core) and PO_output (serial data from core).
- Converts parallel read/write commands into bit-serial pin sequences, LSB first.
- Used on the harness/companion side and in the verification environment to drive the core exactly as the pads do.

Parameters:
- DATA_W, 32, max bits per transfer and width of wdata/rdata.
- SEL_W, 16, width of the register-select bus.
- LEN_W, 6, width of cmd_len; must satisfy 2**LEN_W > DATA_W.
- RD_LAT, 2, cycles from select/direction presented to first valid read bit on PO_output; legal range 0..7.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write to core, 0 = read from core.
- cmd_sel  in  SEL_W  register select driven onto pin_in_out_sel.
- cmd_len  in  LEN_W  bit count; 0 or >DATA_W means DATA_W.
- cmd_wdata  in  DATA_W  write data, LSB shifted first.
- rsp_valid  out  1  read data available (reads only).
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data, first received bit in bit 0, unused upper bits 0.
- pin_inputnoutput  out  1  direction to core.
- pin_input  out  1  serial write bit to core.
- pin_in_out_sel  out  SEL_W  register select to core.
- pin_output  in  1  serial read bit from core (PO_output).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous: state IDLE; outputs cmd_ready=1, rsp_valid=0, rsp_rdata=0, pin_inputnoutput=0, pin_input=0, pin_in_out_sel=0, busy=0. Internal counters and shift registers cleared.
- Reset asserted mid-transfer aborts it; no response is produced; pins return to idle in the same cycle.
- All pin outputs are registered; sel=0 with inputnoutput=0 is the bus idle condition.
- States: IDLE, WRITE, RD_WAIT, READ, RESP, GAP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch sel, effective length N (1..DATA_W), write flag and wdata.
  - Next state is WRITE if the write flag is set, otherwise RD_WAIT, or READ when RD_LAT=0.
- WRITE, exactly N cycles:
  - pin_in_out_sel=sel, pin_inputnoutput=1, pin_input=wdata[k] in cycle k (k=0..N-1).
  - Then GAP.
- RD_WAIT, exactly RD_LAT cycles:
  - pin_in_out_sel=sel, pin_inputnoutput=0, pin_input=0.
  - pin_output is ignored.
- READ, exactly N cycles:
  - sel and direction held as in RD_WAIT.
  - pin_output is sampled each cycle into rdata bit k.
  - Then RESP.
- RESP:
  - Pins idle; rsp_valid=1 and rsp_rdata stable until rsp_valid & rsp_ready.
  - Then GAP. rsp_valid may stay high for any number of cycles; data must not change.
- GAP: exactly 1 cycle with pins idle, then IDLE. This guarantees at least one idle bus cycle between any two transfers.
- cmd_ready=0 in every state except IDLE. Back-to-back accepts are therefore spaced by N+2 cycles for writes and N+RD_LAT+3 cycles minimum for reads.
- Commands offered while busy are held by the requester; none are dropped or queued.
- Bit counter width is LEN_W; it counts 0..N-1 with no wrap beyond N.

Test Plan:
- Write, sel=0x0003, len=8, wdata=0xA5:
  - pin_inputnoutput=1 and sel=0x0003 for exactly 8 cycles.
  - pin_input sequence 1,0,1,0,0,1,0,1.
  - Then 1 idle cycle before cmd_ready=1.
- Read, sel=0x0010, len=4, RD_LAT=2; bench drives pin_output=1,1,0,1 starting 2 cycles after sel appears:
  - rsp_rdata=0x0000000B with rsp_valid.
  - Bits [31:4]=0.
- len=0 write with wdata=0x80000001:
  - 32 shift cycles.
  - pin_input=1 in first and last cycle, 0 otherwise.
- Response backpressure: rsp_ready held low 5 cycles after read completes:
  - rsp_valid and rsp_rdata stay constant.
  - cmd_ready stays 0 until 2 cycles after the handshake.
- Reset mid-transfer: assert wb_rst_i during cycle 3 of a 16-bit write:
  - Pins idle and cmd_ready=1 immediately.
  - No rsp_valid.
  - A following read completes normally.
- Back-to-back: cmd_valid held high with two writes queued at the requester:
  - Second accept occurs exactly N+2 cycles after the first.
  - One idle bus cycle between the transfers.

Source files
------------

// File: rtl/ldpc_pin_host_if.sv
// Command, response and serial pin signals between a requester, the pin host
// master and the LDPC core pads.
interface ldpc_pin_host_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 16,
    parameter int LEN_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [SEL_W-1:0]  cmd_sel;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              pin_inputnoutput;
    logic              pin_input;
    logic [SEL_W-1:0]  pin_in_out_sel;
    logic              pin_output;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_write, cmd_sel, cmd_len, cmd_wdata, rsp_ready, pin_output,
        output cmd_ready, rsp_valid, rsp_rdata, pin_inputnoutput, pin_input,
        output pin_in_out_sel, busy
    );

    modport master (
        output cmd_valid, cmd_write, cmd_sel, cmd_len, cmd_wdata, rsp_ready, pin_output,
        input  cmd_ready, rsp_valid, rsp_rdata, pin_inputnoutput, pin_input,
        input  pin_in_out_sel, busy
    );
endinterface

// File: rtl/ldpc_pin_host.sv
// Host-side master for the LDPC core serial pin bus: turns parallel read/write
// commands into LSB-first bit-serial pin sequences with registered pin outputs.
module ldpc_pin_host #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 16,
    parameter int LEN_W  = 6,
    parameter int RD_LAT = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    ldpc_pin_host_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, WRITE, RD_WAIT, READ, RESP, GAP} state_e;

    localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(DATA_W);
    localparam logic [2:0]       WAIT_LAST = 3'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        wait_q, wait_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [SEL_W-1:0]  pin_sel_q, pin_sel_d;
    logic              pin_dir_q, pin_dir_d;
    logic              pin_in_q, pin_in_d;
    logic [LEN_W-1:0]  eff_len;
    logic              last_bit;

    assign eff_len  = (bus.cmd_len == '0 || bus.cmd_len > FULL_LEN) ? FULL_LEN : bus.cmd_len;
    assign last_bit = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        wait_d   = wait_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        pin_in_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    sel_d   = bus.cmd_sel;
                    len_d   = eff_len;
                    cnt_d   = '0;
                    wait_d  = '0;
                    wdata_d = bus.cmd_wdata;
                    rdata_d = '0;
                    if (bus.cmd_write) begin
                        state_d  = WRITE;
                        pin_in_d = bus.cmd_wdata[0];
                    end else begin
                        state_d = (RD_LAT == 0) ? READ : RD_WAIT;
                    end
                end
            end
            WRITE: begin
                // wdata_q[0] is the bit on the pin this cycle; line up the next one
                if (last_bit) begin
                    state_d = GAP;
                end else begin
                    cnt_d    = cnt_q + LEN_W'(1);
                    wdata_d  = wdata_q >> 1;
                    pin_in_d = wdata_q[1];
                end
            end
            RD_WAIT: begin
                if (wait_q == WAIT_LAST) state_d = READ;
                else                     wait_d  = wait_q + 3'd1;
            end
            READ: begin
                rdata_d = rdata_q | (DATA_W'(bus.pin_output) << cnt_q);
                if (last_bit) state_d = RESP;
                else          cnt_d   = cnt_q + LEN_W'(1);
            end
            RESP: begin
                if (bus.rsp_ready) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Pins follow the state being entered so they come straight off flops
        pin_sel_d = (state_d == WRITE || state_d == RD_WAIT || state_d == READ) ? sel_d : '0;
        pin_dir_d = (state_d == WRITE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            wait_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            pin_sel_q <= '0;
            pin_dir_q <= 1'b0;
            pin_in_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            wait_q    <= wait_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            pin_sel_q <= pin_sel_d;
            pin_dir_q <= pin_dir_d;
            pin_in_q  <= pin_in_d;
        end
    end

    assign bus.cmd_ready        = (state_q == IDLE);
    assign bus.busy             = (state_q != IDLE);
    assign bus.rsp_valid        = (state_q == RESP);
    assign bus.rsp_rdata        = rdata_q;
    assign bus.pin_inputnoutput = pin_dir_q;
    assign bus.pin_input        = pin_in_q;
    assign bus.pin_in_out_sel   = pin_sel_q;

endmodule
